// File: rtl/mem_responder_if.sv
// Request/ready handshake bundle between the CPU memory port and mem_responder.
// The master side issues requests; the slave side returns completion and status.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;
  logic [7:0]  err_count;

  modport master (
    output req, wr, addr, wdata,
    input  ready, rdata, busy, addr_err, err_count
  );

  modport slave (
    input  req, wr, addr, wdata,
    output ready, rdata, busy, addr_err, err_count
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM behind a request/ready handshake with WAIT_CYCLES wait states,
// alignment/range checking and a saturating rejected-request counter.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mem_responder_if.slave  io_bus
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
  localparam logic [3:0]  WAIT_L  = WAIT_CYCLES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic          r_wr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_ready;
  logic          r_addr_err;
  logic [31:0]   r_rdata;
  logic [7:0]    r_err_count;
  logic          w_accept;
  logic          w_reject;
  logic [AW-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && io_bus.req;
  assign w_reject = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= DEPTH_L);
  assign w_idx    = r_addr[AW+1:2];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (io_bus.req) w_state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_wait_cnt == 4'd1) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_wr       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wr       <= io_bus.wr;
        r_addr     <= io_bus.addr;
        r_wdata    <= io_bus.wdata;
        r_wait_cnt <= WAIT_L;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // Commit happens on the edge that leaves ACCESS; rejected writes never touch the array.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready     <= 1'b0;
      r_addr_err  <= 1'b0;
      r_rdata     <= 32'd0;
      r_err_count <= 8'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
    end else begin
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
      if (r_state == S_ACCESS) begin
        r_ready    <= 1'b1;
        r_addr_err <= w_reject;
        if (w_reject) begin
          if (!r_wr) r_rdata <= 32'd0;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end else if (r_wr) begin
          r_mem[w_idx] <= r_wdata;
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  assign io_bus.ready     = r_ready;
  assign io_bus.addr_err  = r_addr_err;
  assign io_bus.rdata     = r_rdata;
  assign io_bus.err_count = r_err_count;
  assign io_bus.busy      = (r_state != S_IDLE);

endmodule
